// File: rtl/adder_bist_driver_pkg.sv
// Shared definitions for the adder self-test driver: FSM state encodings
// and the derived vector width.
package adder_bist_driver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } bist_state_e;

   localparam int SETTLE_CNT_W = 4;

   // Packed {c_in,b,a} vector width for a given operand width.
   function automatic int vec_width(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/adder_vec_gen.sv
// Exhaustive operand sequencer: vector counter, terminal flag and the
// registered operands presented to the adder under test.
module adder_vec_gen
   import adder_bist_driver_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             step_i,
   input  logic             load_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             c_in_o,
   output logic             last_o
);

   localparam int VEC_W = vec_width(WIDTH);
   localparam logic [VEC_W-1:0] VEC_ONE  = {{(VEC_W-1){1'b0}}, 1'b1};
   localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};

   logic [VEC_W-1:0] vec_r;

   // Vector counter and operand registers; operands only change on load.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         vec_r  <= {VEC_W{1'b0}};
         a_o    <= {WIDTH{1'b0}};
         b_o    <= {WIDTH{1'b0}};
         c_in_o <= 1'b0;
      end else begin
         if (clr_i) begin
            vec_r <= {VEC_W{1'b0}};
         end else if (step_i) begin
            vec_r <= vec_r + VEC_ONE;
         end
         if (load_i) begin
            {c_in_o, b_o, a_o} <= vec_r;
         end
      end
   end

   assign last_o = (vec_r == VEC_LAST);

endmodule

// File: rtl/adder_bist_driver.sv
// Self-test initiator for a WIDTH-bit adder: sweeps every {c_in,b,a}
// combination, checks {c_out,sum}, counts mismatches, keeps the first failure.
module adder_bist_driver
   import adder_bist_driver_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 10
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         start_i,
   output logic [WIDTH-1:0]             a_o,
   output logic [WIDTH-1:0]             b_o,
   output logic                         c_in_o,
   input  logic [WIDTH-1:0]             sum_i,
   input  logic                         c_out_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         pass_o,
   output logic [ERR_W-1:0]             err_cnt_o,
   output logic                         fail_valid_o,
   output logic [vec_width(WIDTH)-1:0]  fail_vec_o,
   output logic [WIDTH:0]               fail_got_o
);

   localparam int VEC_W = vec_width(WIDTH);
   localparam bit HAS_WAIT = (SETTLE > 0);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
      SETTLE_CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_ONE = {{(SETTLE_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   function automatic logic [WIDTH:0] add_ref(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             c);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   endfunction

   bist_state_e             state_r;
   logic [SETTLE_CNT_W-1:0] settle_cnt_r;
   logic                    busy_r, done_r, pass_r, fail_valid_r;
   logic [ERR_W-1:0]        err_cnt_r;
   logic [VEC_W-1:0]        fail_vec_r;
   logic [WIDTH:0]          fail_got_r;

   logic                    clr_s, step_s, load_s, last_s;
   logic [WIDTH:0]          got_s;
   logic                    mismatch_s;
   logic [ERR_W-1:0]        err_next_s;

   adder_vec_gen #(.WIDTH(WIDTH)) u_vec_gen (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (clr_s),
      .step_i  (step_s),
      .load_i  (load_s),
      .a_o     (a_o),
      .b_o     (b_o),
      .c_in_o  (c_in_o),
      .last_o  (last_s)
   );

   // Sequencer strobes derived from the current state.
   always_comb begin
      clr_s  = 1'b0;
      step_s = 1'b0;
      load_s = 1'b0;
      if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
         clr_s = start_i;
      end else if (state_r == ST_DRIVE) begin
         load_s = 1'b1;
      end else if (state_r == ST_SAMPLE) begin
         step_s = ~last_s;
      end else begin
         clr_s = 1'b0;
      end
   end

   // Result comparison and saturating error increment.
   always_comb begin
      got_s      = {c_out_i, sum_i};
      mismatch_s = (got_s != add_ref(a_o, b_o, c_in_o));
      if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
         err_next_s = err_cnt_r + ERR_ONE;
      end else begin
         err_next_s = err_cnt_r;
      end
   end

   // Sweep FSM with settle counter, error counter and first-fail capture.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= {SETTLE_CNT_W{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_cnt_r    <= {ERR_W{1'b0}};
         fail_valid_r <= 1'b0;
         fail_vec_r   <= {VEC_W{1'b0}};
         fail_got_r   <= {(WIDTH+1){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_r      <= ST_DRIVE;
                  settle_cnt_r <= {SETTLE_CNT_W{1'b0}};
                  busy_r       <= 1'b1;
                  done_r       <= 1'b0;
                  pass_r       <= 1'b0;
                  err_cnt_r    <= {ERR_W{1'b0}};
                  fail_valid_r <= 1'b0;
                  fail_vec_r   <= {VEC_W{1'b0}};
                  fail_got_r   <= {(WIDTH+1){1'b0}};
               end
            end
            ST_DRIVE: begin
               settle_cnt_r <= {SETTLE_CNT_W{1'b0}};
               state_r      <= HAS_WAIT ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  settle_cnt_r <= {SETTLE_CNT_W{1'b0}};
                  state_r      <= ST_SAMPLE;
               end else begin
                  settle_cnt_r <= settle_cnt_r + SETTLE_ONE;
               end
            end
            ST_SAMPLE: begin
               err_cnt_r <= err_next_s;
               if (mismatch_s && !fail_valid_r) begin
                  fail_valid_r <= 1'b1;
                  fail_vec_r   <= {c_in_o, b_o, a_o};
                  fail_got_r   <= got_s;
               end
               if (last_s) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_next_s == {ERR_W{1'b0}});
               end else begin
                  state_r <= ST_DRIVE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = busy_r;
   assign done_o       = done_r;
   assign pass_o       = pass_r;
   assign err_cnt_o    = err_cnt_r;
   assign fail_valid_o = fail_valid_r;
   assign fail_vec_o   = fail_vec_r;
   assign fail_got_o   = fail_got_r;

endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: three instances (SETTLE=1/ERR_W=10,
// SETTLE=1/ERR_W=4, SETTLE=0/ERR_W=10) each beside a fault-injectable adder.
module tb_adder_bist_driver;

   logic       clk = 1'b0;
   logic [2:0] rst_s = 3'b111;
   logic [2:0] start_s = 3'b000;
   logic [1:0] mode_s [3];

   logic [2:0]  obs_busy, obs_done, obs_pass, obs_fv;
   logic [29:0] obs_err;
   logic [26:0] obs_vec;
   logic [26:0] obs_fvec;
   logic [14:0] obs_got;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int set_of(input int g);
      return (g == 2) ? 0 : 1;
   endfunction
   function automatic int emax_of(input int g);
      return (g == 1) ? 15 : 1023;
   endfunction
   function automatic int ncyc_of(input int g);
      return 512 * (set_of(g) + 2);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int S = (g == 2) ? 0 : 1;
      localparam int E = (g == 1) ? 4 : 10;
      logic [3:0]   a_w, b_w, sum_w;
      logic         cin_w, cout_w, busy_w, done_w, pass_w, fv_w;
      logic [E-1:0] err_w;
      logic [8:0]   fvec_w;
      logic [4:0]   got_w, r_w;

      always_comb begin
         r_w = 5'(a_w) + 5'(b_w) + 5'(cin_w);
         if (mode_s[g] == 2'd1) r_w[0] = 1'b0;
         else if (mode_s[g] == 2'd2) r_w[4] = 1'b0;
      end
      assign {cout_w, sum_w} = r_w;

      adder_bist_driver #(.WIDTH(4), .SETTLE(S), .ERR_W(E)) u_dut (
         .clk_i        (clk),
         .reset_i      (rst_s[g]),
         .start_i      (start_s[g]),
         .a_o          (a_w),
         .b_o          (b_w),
         .c_in_o       (cin_w),
         .sum_i        (sum_w),
         .c_out_i      (cout_w),
         .busy_o       (busy_w),
         .done_o       (done_w),
         .pass_o       (pass_w),
         .err_cnt_o    (err_w),
         .fail_valid_o (fv_w),
         .fail_vec_o   (fvec_w),
         .fail_got_o   (got_w)
      );

      assign obs_busy[g]         = busy_w;
      assign obs_done[g]         = done_w;
      assign obs_pass[g]         = pass_w;
      assign obs_fv[g]           = fv_w;
      assign obs_err[g*10 +: 10] = 10'(err_w);
      assign obs_vec[g*9 +: 9]   = {cin_w, b_w, a_w};
      assign obs_fvec[g*9 +: 9]  = fvec_w;
      assign obs_got[g*5 +: 5]   = got_w;
   end

   // Reference tables per fault mode: cumulative fail counts, first fail, observed sums.
   int         cum [3][513];
   int         first_f [3];
   logic [4:0] got_t [3][512];

   initial begin
      for (int m = 0; m < 3; m++) begin
         first_f[m] = 512;
         cum[m][0] = 0;
         for (int v = 0; v < 512; v++) begin
            int e, o;
            e = (v % 16) + ((v / 16) % 16) + (v / 256);
            o = (m == 1) ? (e & 30) : (m == 2) ? (e & 15) : e;
            got_t[m][v] = 5'(o);
            cum[m][v+1] = cum[m][v] + ((o != e) ? 1 : 0);
            if (o != e && first_f[m] == 512) first_f[m] = v;
         end
      end
   end

   // Timeline model: edges since the accepted start of each instance.
   bit act_m [3] = '{1'b0, 1'b0, 1'b0};
   int t_m [3]   = '{0, 0, 0};
   int mode_m [3] = '{0, 0, 0};

   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rst_s[g]) begin
            act_m[g] <= 1'b0;
         end else if (start_s[g] && (!act_m[g] || t_m[g] >= ncyc_of(g))) begin
            act_m[g]  <= 1'b1;
            t_m[g]    <= 0;
            mode_m[g] <= int'(mode_s[g]);
         end else if (act_m[g] && t_m[g] < 100000) begin
            t_m[g] <= t_m[g] + 1;
         end
      end
   end

   // Per-cycle comparison of every instance against the timeline model.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         logic [9:0] e_err;
         logic [8:0] e_fvec, e_vec;
         logic [4:0] e_got;
         logic e_busy, e_done, e_pass, e_fv, ok;
         int l, c, k, m, t, n;
         e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_fv = 1'b0;
         e_err = 10'd0; e_fvec = 9'd0; e_got = 5'd0; e_vec = 9'd0;
         ok = 1'b1;
         if (!rst_s[g] && act_m[g]) begin
            l = set_of(g) + 2; n = ncyc_of(g); t = t_m[g]; m = mode_m[g];
            e_busy = (t < n);
            e_done = (t >= n);
            c = t / l; if (c > 512) c = 512;
            e_err = 10'((cum[m][c] > emax_of(g)) ? emax_of(g) : cum[m][c]);
            e_fv = (first_f[m] < c);
            if (e_fv) begin
               e_fvec = 9'(first_f[m]);
               e_got  = got_t[m][first_f[m]];
            end
            e_pass = e_done && (cum[m][512] == 0);
            k = (t >= 1) ? (t - 1) / l : 0; if (k > 511) k = 511;
            e_vec = 9'(k);
            if (t >= 1 && obs_vec[g*9 +: 9] != e_vec) ok = 1'b0;
            if (e_done && obs_pass[g] != e_pass) ok = 1'b0;
         end else begin
            if (obs_vec[g*9 +: 9] != 9'd0 || obs_pass[g] != 1'b0) ok = 1'b0;
         end
         if (obs_busy[g] != e_busy || obs_done[g] != e_done || obs_fv[g] != e_fv ||
             obs_err[g*10 +: 10] != e_err || obs_fvec[g*9 +: 9] != e_fvec ||
             obs_got[g*5 +: 5] != e_got) ok = 1'b0;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL model inst=%0d t=%0d busy=%b/%b done=%b/%b pass=%b/%b err=%0d/%0d fv=%b/%b fvec=%0d/%0d got=%0d/%0d vec=%0d/%0d",
                     g, t_m[g], obs_busy[g], e_busy, obs_done[g], e_done, obs_pass[g], e_pass,
                     obs_err[g*10 +: 10], e_err, obs_fv[g], e_fv, obs_fvec[g*9 +: 9], e_fvec,
                     obs_got[g*5 +: 5], e_got, obs_vec[g*9 +: 9], e_vec);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic kick(input logic [2:0] mask);
      @(posedge clk); #1;
      start_s = mask;
      @(posedge clk); #1;
      start_s = 3'b000;
   endtask

   // Count edges after the start edge until each selected done_o rises.
   task automatic wait_done(input logic [2:0] mask, input bit pulse,
                            output int d0, output int d1, output int d2);
      int d [3];
      d = '{-1, -1, -1};
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(posedge clk); #1;
         start_s[0] = pulse && (cyc == 100);
         for (int g = 0; g < 3; g++)
            if (mask[g] && d[g] < 0 && obs_done[g]) d[g] = cyc;
         if ((!mask[0] || d[0] >= 0) && (!mask[1] || d[1] >= 0) && (!mask[2] || d[2] >= 0))
            break;
      end
      start_s[0] = 1'b0;
      d0 = d[0]; d1 = d[1]; d2 = d[2];
   endtask

   initial begin
      int d0, d1, d2;
      mode_s[0] = 2'd0; mode_s[1] = 2'd1; mode_s[2] = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst_s = 3'b000;
      check("reset_busy", int'(obs_busy[0]), 0);
      check("reset_done", int'(obs_done[0]), 0);
      check("reset_err",  int'(obs_err[9:0]), 0);

      // Good adder, saturating stuck-sum0 adder, SETTLE=0 good adder; mid-sweep start on inst 0.
      kick(3'b111);
      wait_done(3'b111, 1'b1, d0, d1, d2);
      check("good_done_cycle", d0, 1536);
      check("good_pass", int'(obs_pass[0]), 1);
      check("good_err", int'(obs_err[9:0]), 0);
      check("good_fail_valid", int'(obs_fv[0]), 0);
      check("sat_done_cycle", d1, 1536);
      check("sat_err", int'(obs_err[19:10]), 15);
      check("sat_fail_vec", int'(obs_fvec[17:9]), 1);
      check("sat_pass", int'(obs_pass[1]), 0);
      check("s0_good_done_cycle", d2, 1024);
      check("s0_good_pass", int'(obs_pass[2]), 1);

      // Stuck sum[0] on both settle variants, restarted from DONE.
      mode_s[0] = 2'd1; mode_s[2] = 2'd1;
      kick(3'b101);
      wait_done(3'b101, 1'b0, d0, d1, d2);
      check("sum0_done_cycle", d0, 1536);
      check("sum0_err", int'(obs_err[9:0]), 256);
      check("sum0_fail_vec", int'(obs_fvec[8:0]), 1);
      check("sum0_fail_got", int'(obs_got[4:0]), 0);
      check("sum0_pass", int'(obs_pass[0]), 0);
      check("s0_sum0_done_cycle", d2, 1024);
      check("s0_sum0_err", int'(obs_err[29:20]), 256);
      check("s0_sum0_fail_vec", int'(obs_fvec[26:18]), 1);

      // Stuck carry-out.
      mode_s[0] = 2'd2;
      kick(3'b001);
      wait_done(3'b001, 1'b0, d0, d1, d2);
      check("cout_err", int'(obs_err[9:0]), 256);
      check("cout_fail_vec", int'(obs_fvec[8:0]), 31);
      check("cout_fail_got", int'(obs_got[4:0]), 0);

      // Asynchronous reset mid-sweep, then a clean sweep.
      mode_s[0] = 2'd0;
      kick(3'b001);
      repeat (700) @(posedge clk);
      #2 rst_s[0] = 1'b1;
      #1;
      check("async_rst_busy", int'(obs_busy[0]), 0);
      check("async_rst_vec", int'(obs_vec[8:0]), 0);
      check("async_rst_err", int'(obs_err[9:0]), 0);
      @(posedge clk); #1;
      rst_s[0] = 1'b0;
      kick(3'b001);
      wait_done(3'b001, 1'b0, d0, d1, d2);
      check("post_rst_done_cycle", d0, 1536);
      check("post_rst_pass", int'(obs_pass[0]), 1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
